// File: rtl/tag_anc_pkg.sv
// Shared definitions for the tag phase sequencer: state encoding and
// power-on configuration defaults.
package tag_anc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_t;

   localparam int unsigned DEF_NSIG    = 32768;
   localparam int unsigned DEF_NSYMB   = 512;
   localparam int unsigned DEF_NLOC    = 7;
   localparam int          DEF_DPH_INC = -16384;

   // Clamp a default count to the largest value a counter of the given width holds.
   function automatic logic [31:0] sat_cnt(input int unsigned value, input int unsigned width);
      logic [31:0] lim;
      lim = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value > lim) ? lim : value;
   endfunction

endpackage

// File: rtl/tag_ph_offset.sv
// Per-channel phase: base phase plus a fixed multiple of the channel step.
// Output is forced to zero while the word is not valid.
module tag_ph_offset #(
   parameter int PHASE_WIDTH = 24,
   parameter int CH_IDX      = 0
) (
   input  logic                   en,
   input  logic [PHASE_WIDTH-1:0] base,
   input  logic [PHASE_WIDTH-1:0] step,
   output logic [PHASE_WIDTH-1:0] phase
);

   logic [PHASE_WIDTH-1:0] offset;

   assign offset = PHASE_WIDTH'(CH_IDX) * step;
   assign phase  = en ? (base + offset) : '0;

endmodule

// File: rtl/tag_phase_seq.sv
// Multi-channel phase sequencer: emits per-sample phase words over an
// AXI-stream style output, organised as samples / symbols / frames.
module tag_phase_seq
   import tag_anc_pkg::*;
#(
   parameter int PHASE_WIDTH = 24,
   parameter int CNT_WIDTH   = 16,
   parameter int NCHAN       = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         srst,
   input  logic                         cfg_load,
   input  logic [CNT_WIDTH-1:0]         cfg_nsig,
   input  logic [CNT_WIDTH-1:0]         cfg_nsymb,
   input  logic [CNT_WIDTH-1:0]         cfg_nloc,
   input  logic [PHASE_WIDTH-1:0]       cfg_start_ph,
   input  logic [PHASE_WIDTH-1:0]       cfg_start_ph_inc,
   input  logic [PHASE_WIDTH-1:0]       cfg_dph_inc,
   input  logic [PHASE_WIDTH-1:0]       cfg_nph_shift,
   input  logic [PHASE_WIDTH-1:0]       cfg_ch_ph_step,
   input  logic                         cfg_oneshot,
   input  logic                         start,
   input  logic                         stop,
   output logic [NCHAN*PHASE_WIDTH-1:0] m_axis_phase_tdata,
   output logic                         m_axis_phase_tvalid,
   input  logic                         m_axis_phase_tready,
   output logic                         m_axis_phase_tlast,
   output logic                         m_axis_phase_tuser,
   output logic                         sync_ready,
   output logic                         busy,
   output logic [CNT_WIDTH-1:0]         sigN,
   output logic [CNT_WIDTH-1:0]         symbN
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Reset release synchroniser: assertion is immediate, deassertion follows clk.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= '0;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n_int = rst_sync_q[1];

   seq_state_t state_q, state_d;

   logic [CNT_WIDTH-1:0]   nsig_r, nsymb_r, nloc_r;
   logic [PHASE_WIDTH-1:0] start_ph_r, start_inc_r, dph_inc_r, nph_shift_r, ch_step_r;
   logic                   oneshot_r;
   logic                   load_en;

   assign load_en = cfg_load && (state_q == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         nsig_r      <= CNT_WIDTH'(sat_cnt(DEF_NSIG, CNT_WIDTH));
         nsymb_r     <= CNT_WIDTH'(sat_cnt(DEF_NSYMB, CNT_WIDTH));
         nloc_r      <= CNT_WIDTH'(sat_cnt(DEF_NLOC, CNT_WIDTH));
         start_ph_r  <= '0;
         start_inc_r <= '0;
         dph_inc_r   <= PHASE_WIDTH'(DEF_DPH_INC);
         nph_shift_r <= '0;
         ch_step_r   <= '0;
         oneshot_r   <= 1'b0;
      end else if (load_en) begin
         nsig_r      <= cfg_nsig;
         nsymb_r     <= cfg_nsymb;
         nloc_r      <= cfg_nloc;
         start_ph_r  <= cfg_start_ph;
         start_inc_r <= cfg_start_ph_inc;
         dph_inc_r   <= cfg_dph_inc;
         nph_shift_r <= cfg_nph_shift;
         ch_step_r   <= cfg_ch_ph_step;
         oneshot_r   <= cfg_oneshot;
      end
   end

   // A start coinciding with cfg_load seeds the first word from the incoming values.
   logic [PHASE_WIDTH-1:0] start_ph_sel, start_inc_sel;
   assign start_ph_sel  = load_en ? cfg_start_ph     : start_ph_r;
   assign start_inc_sel = load_en ? cfg_start_ph_inc : start_inc_r;

   logic [CNT_WIDTH-1:0] nsig_eff, nsymb_eff, nloc_eff;
   assign nsig_eff  = (nsig_r  == '0) ? CNT_ONE : nsig_r;
   assign nsymb_eff = (nsymb_r == '0) ? CNT_ONE : nsymb_r;
   assign nloc_eff  = (nloc_r  == '0) ? CNT_ONE : nloc_r;

   logic [PHASE_WIDTH-1:0] base_q, base_d, inc_q, inc_d, sp_q, sp_d;
   logic [CNT_WIDTH-1:0]   sig_q, sig_d, symb_q, symb_d, loc_q, loc_d, loc_inc;
   logic                   valid, hs, last_smp, last_sym;

   assign valid    = (state_q != ST_IDLE);
   assign hs       = valid && m_axis_phase_tready;
   assign last_smp = (sig_q >= nsig_eff);
   assign last_sym = (symb_q >= nsymb_eff);
   assign loc_inc  = (loc_q >= nloc_eff) ? loc_q : (loc_q + CNT_ONE);

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         inc_q   <= '0;
         sp_q    <= '0;
         sig_q   <= CNT_ONE;
         symb_q  <= CNT_ONE;
         loc_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         inc_q   <= inc_d;
         sp_q    <= sp_d;
         sig_q   <= sig_d;
         symb_q  <= symb_d;
         loc_q   <= loc_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      base_d             = base_q;
      inc_d              = inc_q;
      sp_d               = sp_q;
      sig_d              = sig_q;
      symb_d             = symb_q;
      loc_d              = loc_q;
      m_axis_phase_tlast = valid && last_smp;
      m_axis_phase_tuser = valid && last_smp && last_sym;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN;
               loc_d   = '0;
               sig_d   = CNT_ONE;
               symb_d  = CNT_ONE;
               sp_d    = start_ph_sel;
               base_d  = start_ph_sel;
               inc_d   = start_inc_sel;
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (hs) begin
               if (!last_smp) begin
                  sig_d  = sig_q + CNT_ONE;
                  base_d = base_q + inc_q;
               end else if (!last_sym) begin
                  sig_d  = CNT_ONE;
                  symb_d = symb_q + CNT_ONE;
                  sp_d   = sp_q - nph_shift_r;
                  base_d = sp_q - nph_shift_r;
                  inc_d  = inc_q + dph_inc_r;
               end else begin
                  sig_d  = CNT_ONE;
                  symb_d = CNT_ONE;
                  sp_d   = start_ph_r;
                  base_d = start_ph_r;
                  inc_d  = start_inc_r;
                  loc_d  = loc_inc;
               end
            end
            // Completing the final one-shot frame wins over a concurrent stop.
            if (state_q == ST_RUN) begin
               if (hs && last_smp && last_sym && oneshot_r && (loc_inc == nloc_eff))
                  state_d = ST_IDLE;
               else if (stop)
                  state_d = ST_DRAIN;
            end else if (hs && last_smp) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (srst) begin
         state_d = ST_IDLE;
         base_d  = '0;
         inc_d   = '0;
         sp_d    = '0;
         sig_d   = CNT_ONE;
         symb_d  = CNT_ONE;
         loc_d   = '0;
      end
   end

   for (genvar k = 0; k < NCHAN; k++) begin : g_ch
      tag_ph_offset #(
         .PHASE_WIDTH (PHASE_WIDTH),
         .CH_IDX      (k)
      ) u_ph_offset (
         .en    (valid),
         .base  (base_q),
         .step  (ch_step_r),
         .phase (m_axis_phase_tdata[k*PHASE_WIDTH +: PHASE_WIDTH])
      );
   end

   assign m_axis_phase_tvalid = valid;
   assign busy                = valid;
   assign sync_ready          = (loc_q == nloc_eff);
   assign sigN                = sig_q;
   assign symbN               = symb_q;

endmodule

// File: tb/tb_tag_phase_seq.sv
// Directed and randomised checks of tag_phase_seq against a closed-form
// phase model (sp, inc and base computed directly from symbol/sample index).
module tb_tag_phase_seq;

   localparam int PW  = 24;
   localparam int CW  = 16;
   localparam int NCH = 4;

   logic              clk = 1'b0;
   logic              reset_n, srst, cfg_load, cfg_oneshot, start, stop, tready;
   logic [CW-1:0]     cfg_nsig, cfg_nsymb, cfg_nloc;
   logic [PW-1:0]     cfg_start_ph, cfg_start_ph_inc, cfg_dph_inc, cfg_nph_shift, cfg_ch_ph_step;
   logic [NCH*PW-1:0] tdata;
   logic              tvalid, tlast, tuser, sync_ready, busy;
   logic [CW-1:0]     sigN, symbN;

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned   m_nsig, m_nsymb;
   logic [PW-1:0] m_start, m_sinc, m_dph, m_shift, m_step;
   int unsigned   widx;

   logic [PW-1:0] cap_ph[$];
   logic          cap_last[$];
   logic          cap_user[$];

   always #5 clk = ~clk;

   tag_phase_seq #(
      .PHASE_WIDTH (PW),
      .CNT_WIDTH   (CW),
      .NCHAN       (NCH)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .srst                (srst),
      .cfg_load            (cfg_load),
      .cfg_nsig            (cfg_nsig),
      .cfg_nsymb           (cfg_nsymb),
      .cfg_nloc            (cfg_nloc),
      .cfg_start_ph        (cfg_start_ph),
      .cfg_start_ph_inc    (cfg_start_ph_inc),
      .cfg_dph_inc         (cfg_dph_inc),
      .cfg_nph_shift       (cfg_nph_shift),
      .cfg_ch_ph_step      (cfg_ch_ph_step),
      .cfg_oneshot         (cfg_oneshot),
      .start               (start),
      .stop                (stop),
      .m_axis_phase_tdata  (tdata),
      .m_axis_phase_tvalid (tvalid),
      .m_axis_phase_tready (tready),
      .m_axis_phase_tlast  (tlast),
      .m_axis_phase_tuser  (tuser),
      .sync_ready          (sync_ready),
      .busy                (busy),
      .sigN                (sigN),
      .symbN               (symbN)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned eff(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic logic [PW-1:0] exp_phase(input int unsigned s, input int unsigned n,
                                                input int unsigned k);
      logic [PW-1:0] sp, inc, base;
      sp   = m_start - PW'(s - 1) * m_shift;
      inc  = m_sinc + PW'(s - 1) * m_dph;
      base = sp + PW'(n - 1) * inc;
      return base + PW'(k) * m_step;
   endfunction

   task automatic check_word();
      int unsigned       ns, nsy, pos, s, n;
      logic [NCH*PW-1:0] exp_d;
      ns  = eff(m_nsig);
      nsy = eff(m_nsymb);
      pos = widx % (ns * nsy);
      s   = pos / ns + 1;
      n   = pos % ns + 1;
      for (int k = 0; k < NCH; k++) exp_d[k*PW +: PW] = exp_phase(s, n, k);
      check($sformatf("w%0d_tdata", widx), 128'(tdata), 128'(exp_d));
      check($sformatf("w%0d_tlast", widx), tlast, n == ns);
      check($sformatf("w%0d_tuser", widx), tuser, (n == ns) && (s == nsy));
      check($sformatf("w%0d_sigN", widx), sigN, CW'(n));
      check($sformatf("w%0d_symbN", widx), symbN, CW'(s));
      widx++;
   endtask

   // pat: 0 = always ready, 1 = ready pattern 1,0,0,1, other = random ready
   task automatic stream(input int nwords, input int pat, input int stop_after);
      int                cnt = 0;
      int                cyc = 0;
      logic              held_v = 1'b0;
      logic [NCH*PW-1:0] held_d;
      logic              held_l;
      logic [CW-1:0]     held_n;
      while (cnt < nwords && cyc < 4000) begin
         @(negedge clk);
         if (held_v) begin
            check("stall_tvalid", tvalid, 1'b1);
            check("stall_tdata", 128'(tdata), 128'(held_d));
            check("stall_tlast", tlast, held_l);
            check("stall_sigN", sigN, held_n);
         end
         held_v = 1'b0;
         stop   = 1'b0;
         case (pat)
            0:       tready = 1'b1;
            1:       tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         cyc++;
         if (tvalid) begin
            if (tready) begin
               cap_ph.push_back(tdata[PW-1:0]);
               cap_last.push_back(tlast);
               cap_user.push_back(tuser);
               check_word();
               cnt++;
               if (cnt == stop_after) stop = 1'b1;
            end else begin
               held_v = 1'b1;
               held_d = tdata;
               held_l = tlast;
               held_n = sigN;
            end
         end
      end
      if (cnt < nwords) check("stream_timeout_words", cnt, nwords);
   endtask

   task automatic set_cfg(input int unsigned nsig, input int unsigned nsymb, input int unsigned nloc,
                          input logic oneshot, input logic [PW-1:0] sp, input logic [PW-1:0] sinc,
                          input logic [PW-1:0] dph, input logic [PW-1:0] shift,
                          input logic [PW-1:0] step);
      cfg_nsig         = CW'(nsig);
      cfg_nsymb        = CW'(nsymb);
      cfg_nloc         = CW'(nloc);
      cfg_oneshot      = oneshot;
      cfg_start_ph     = sp;
      cfg_start_ph_inc = sinc;
      cfg_dph_inc      = dph;
      cfg_nph_shift    = shift;
      cfg_ch_ph_step   = step;
      m_nsig  = nsig;
      m_nsymb = nsymb;
      m_start = sp;
      m_sinc  = sinc;
      m_dph   = dph;
      m_shift = shift;
      m_step  = step;
   endtask

   task automatic do_start(input logic load);
      @(negedge clk);
      tready   = 1'b0;
      start    = 1'b1;
      cfg_load = load;
      @(negedge clk);
      start    = 1'b0;
      cfg_load = 1'b0;
      check("start_tvalid", tvalid, 1'b1);
      check("start_busy", busy, 1'b1);
      check("start_sync_clear", sync_ready, 1'b0);
      widx = 0;
      cap_ph.delete();
      cap_last.delete();
      cap_user.delete();
   endtask

   task automatic do_stop(input int pat);
      int unsigned n;
      @(negedge clk);
      tready = 1'b0;
      stop   = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n = widx % eff(m_nsig) + 1;
      stream(int'(eff(m_nsig) - n + 1), pat, 0);
      @(negedge clk);
      tready = 1'b0;
      check("drain_end_tvalid", tvalid, 1'b0);
      check("drain_end_busy", busy, 1'b0);
   endtask

   task automatic check_idle_defaults(input string tag);
      check({tag, "_tvalid"}, tvalid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_tlast"}, tlast, 1'b0);
      check({tag, "_tuser"}, tuser, 1'b0);
      check({tag, "_sync"}, sync_ready, 1'b0);
      check({tag, "_tdata"}, 128'(tdata), 128'(0));
      check({tag, "_sigN"}, sigN, CW'(1));
      check({tag, "_symbN"}, symbN, CW'(1));
   endtask

   task automatic check_req20_table(input string tag);
      logic [PW-1:0] tbl [8];
      tbl = '{24'h000000, 24'h000100, 24'h000200, 24'h000300,
              24'hFFFFF0, 24'h0001F0, 24'h0003F0, 24'h0005F0};
      check({tag, "_len"}, cap_ph.size(), 8);
      for (int i = 0; i < 8 && i < cap_ph.size(); i++) begin
         check($sformatf("%s_ph%0d", tag, i), cap_ph[i], tbl[i]);
         check($sformatf("%s_last%0d", tag, i), cap_last[i], (i == 3) || (i == 7));
         check($sformatf("%s_user%0d", tag, i), cap_user[i], i == 7);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      srst    = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      tready  = 1'b0;
      cfg_load = 1'b0;
      set_cfg(0, 0, 0, 1'b0, '0, '0, '0, '0, '0);
      widx = 0;
      repeat (3) @(negedge clk);
      check_idle_defaults("reset");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_defaults("after_reset");

      // Basic sequence, start in the same cycle as cfg_load
      set_cfg(4, 2, 7, 1'b0, 24'h0, 24'h100, 24'h100, 24'h10, PW'($urandom));
      do_start(1'b1);
      stream(8, 0, 0);
      check_req20_table("req20");
      do_stop(0);
      check("req20_sync", sync_ready, 1'b0);

      // Same sequence under a 1,0,0,1 ready pattern
      do_start(1'b0);
      stream(8, 1, 0);
      check_req20_table("req21");
      do_stop(1);

      // Channel offsets on the first word
      set_cfg(4, 2, 7, 1'b0, 24'h100000, 24'h100, 24'h100, 24'h10, 24'h400000);
      do_start(1'b1);
      check("req22_ch", 128'(tdata), 128'({24'hD00000, 24'h900000, 24'h500000, 24'h100000}));
      do_stop(2);

      // One-shot: three 2-word frames, cfg_load during RUN ignored
      set_cfg(2, 1, 3, 1'b1, PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
      do_start(1'b1);
      stream(5, 0, 0);
      check("oneshot_sync_early", sync_ready, 1'b0);
      cfg_load         = 1'b1;
      cfg_nsig         = CW'(9);
      cfg_start_ph     = 24'hABCDEF;
      cfg_ch_ph_step   = 24'h123456;
      stream(1, 0, 0);
      @(negedge clk);
      cfg_load = 1'b0;
      tready   = 1'b0;
      check("oneshot_sync", sync_ready, 1'b1);
      check("oneshot_busy", busy, 1'b0);
      check("oneshot_tvalid", tvalid, 1'b0);
      do_start(1'b0);
      stream(6, 2, 0);
      @(negedge clk);
      tready = 1'b0;
      check("oneshot2_sync", sync_ready, 1'b1);
      check("oneshot2_busy", busy, 1'b0);

      // Stop at word 2 -> words 3,4 then IDLE
      set_cfg(4, 2, 7, 1'b0, PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
      do_start(1'b1);
      stream(4, 0, 2);
      @(negedge clk);
      stop   = 1'b0;
      tready = 1'b0;
      check("stop_idle_tvalid", tvalid, 1'b0);
      check("stop_idle_busy", busy, 1'b0);

      // start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("startstop_tvalid", tvalid, 1'b0);
         @(negedge clk);
      end

      // Zero counts behave as one
      set_cfg(0, 0, 7, 1'b0, PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom), PW'($urandom));
      do_start(1'b1);
      stream(3, 2, 0);
      do_stop(2);

      // Randomised configurations and ready patterns
      for (int r = 0; r < 4; r++) begin
         set_cfg($urandom_range(1, 5), $urandom_range(1, 3), 7, 1'b0, PW'($urandom), PW'($urandom),
                 PW'($urandom), PW'($urandom), PW'($urandom));
         do_start(1'b1);
         stream(int'(eff(m_nsig) * eff(m_nsymb) * 2 + 1), 2, 0);
         do_stop(2);
      end

      // Soft reset mid-run keeps configuration
      do_start(1'b0);
      stream(3, 2, 0);
      @(negedge clk);
      tready = 1'b0;
      srst   = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      check_idle_defaults("srst");
      do_start(1'b0);
      stream(3, 2, 0);
      do_stop(2);

      // Asynchronous reset mid-run
      do_start(1'b0);
      stream(2, 0, 0);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_tvalid", tvalid, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      @(negedge clk);
      tready = 1'b0;
      check_idle_defaults("async_rst");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_defaults("async_rel");

      // Default configuration after reset
      m_nsig  = 32768;
      m_nsymb = 512;
      m_start = '0;
      m_sinc  = '0;
      m_dph   = PW'(-16384);
      m_shift = '0;
      m_step  = '0;
      do_start(1'b0);
      stream(5, 2, 0);
      @(negedge clk);
      tready = 1'b0;
      srst   = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      check_idle_defaults("final_srst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/tag_phase_seq.md
TAG_PHASE_SEQ -- requirements
Module: tag_phase_seq

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 24, phase word width (modulo 2^PHASE_WIDTH).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of sample, symbol and location counters.
REQ-003 SHALL have parameter NCHAN, default 2, number of phase channels, 1..8.
REQ-004 SHALL have the following ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- srst  in  1  synchronous, active-high soft reset.
- cfg_load  in  1  latches all cfg_* inputs (see REQ-014).
- cfg_nsig  in  CNT_WIDTH  samples per symbol.
- cfg_nsymb  in  CNT_WIDTH  symbols per frame.
- cfg_nloc  in  CNT_WIDTH  frames per sync.
- cfg_start_ph  in  PHASE_WIDTH  first phase of each frame.
- cfg_start_ph_inc  in  PHASE_WIDTH  phase increment of symbol 1.
- cfg_dph_inc  in  PHASE_WIDTH  per-symbol increment step.
- cfg_nph_shift  in  PHASE_WIDTH  per-symbol start-phase decrement.
- cfg_ch_ph_step  in  PHASE_WIDTH  phase offset between adjacent channels.
- cfg_oneshot  in  1  1 = stop after cfg_nloc frames.
- start  in  1  begin sequence.
- stop  in  1  graceful stop request.
- m_axis_phase_tdata  out  NCHAN*PHASE_WIDTH  channel k in bits [(k+1)*PHASE_WIDTH-1 : k*PHASE_WIDTH].
- m_axis_phase_tvalid  out  1  output word valid.
- m_axis_phase_tready  in  1  downstream ready.
- m_axis_phase_tlast  out  1  last sample of a symbol.
- m_axis_phase_tuser  out  1  last sample of a frame.
- sync_ready  out  1  location count has reached cfg_nloc.
- busy  out  1  state is not IDLE.
- sigN, symbN  out  CNT_WIDTH each  current sample and symbol index (1-based) of the word on tdata.

Function
REQ-005 SHALL implement the states IDLE, RUN and DRAIN:
- IDLE to RUN on start.
- RUN to DRAIN on stop.
- DRAIN to IDLE on the handshake of a tlast word.
- RUN to IDLE on the handshake of the final frame's tuser word when cfg_oneshot=1 and the location count then equals cfg_nloc.
REQ-006 SHALL treat start and stop asserted in the same cycle as stop (remain IDLE, or RUN to DRAIN).
REQ-007 SHALL assert tvalid only in RUN or DRAIN; the first word SHALL be valid one cycle after the start cycle.
REQ-008 SHALL advance the sequence only on a handshake (tvalid & tready); tdata, tlast, tuser, sigN and symbN SHALL hold stable while tvalid=1 and tready=0.
REQ-009 Sequence for symbol s and sample n:
- base phase of sample 1 = sp(s); base phase of sample n+1 = base phase of sample n + inc(s).
- sp(1) = cfg_start_ph; inc(1) = cfg_start_ph_inc.
- sp(s+1) = sp(s) - cfg_nph_shift; inc(s+1) = inc(s) + cfg_dph_inc.
- all arithmetic wraps modulo 2^PHASE_WIDTH.
REQ-010 Channel k output SHALL equal base + k*cfg_ch_ph_step, mod 2^PHASE_WIDTH, aligned to the same word as the base phase (no inter-channel skew).
REQ-011 SHALL assert tlast when n = nsig, and tuser when n = nsig and s = nsymb.
- After a tuser handshake, the next word SHALL restart at s=1, n=1.
- After a tuser handshake, the location count SHALL increment, saturating at cfg_nloc.
REQ-012 sync_ready SHALL be 1 while the location count equals cfg_nloc; the location count SHALL clear on start from IDLE.
REQ-013 SHALL treat cfg_nsig=0, cfg_nsymb=0 and cfg_nloc=0 as 1.
REQ-014 SHALL accept cfg_load only in IDLE and ignore it otherwise; a start in the same cycle as cfg_load SHALL use the newly loaded values.
REQ-015 srst SHALL take effect in any state: go to IDLE and apply the REQ-016 values on the next edge; the configuration registers SHALL be retained.

Reset
REQ-016 On reset_n=0 the block SHALL asynchronously drive:
- state IDLE; tvalid, tlast, tuser, sync_ready and busy at 0.
- tdata at 0; sigN and symbN at 1; location count at 0.
- configuration registers at: nsig=32768 (saturated to CNT_WIDTH), nsymb=512, nloc=7, dph_inc=-16384, all other configuration fields 0.
REQ-017 Release of reset_n SHALL be synchronised within the block so that deassertion is synchronous to clk.

Structure
REQ-018 The reset configuration defaults and the state encoding SHALL reside in the shared package tag_anc_pkg.
REQ-019 The per-channel offset adder SHALL be one sub-module, tag_ph_offset, instantiated NCHAN times in a generate loop.

Verification
REQ-020 PHASE_WIDTH=24, NCHAN=1, nsig=4, nsymb=2, start_ph=0, start_ph_inc=0x100, dph_inc=0x100, nph_shift=0x10, tready=1 -> phases 000000, 000100, 000200, 000300, FFFFF0, 0001F0, 0003F0, 0005F0; tlast on words 4 and 8; tuser on word 8.
REQ-021 Same configuration, tready toggled 1,0,0,1 repeatedly -> identical 8-word sequence with tdata stable during every stall.
REQ-022 NCHAN=4, ch_ph_step=0x400000, start_ph=0x100000 -> first word channels 0..3 = 100000, 500000, 900000, D00000.
REQ-023 oneshot=1, nloc=3, nsig=2, nsymb=1 -> 6 words, sync_ready rises after the 6th handshake, busy falls; cfg_load during RUN is ignored.
REQ-024 stop asserted at word 2 of nsig=4 -> words 3 and 4 are emitted, word 4 with tlast, then IDLE; simultaneous start+stop in IDLE -> no tvalid.
REQ-025 reset_n pulsed low mid-RUN -> tvalid low within the same cycle, then IDLE with the REQ-016 values.
